// File: rtl/writeback_queue.sv
// Ordered writeback buffer feeding the register-file write port, with RAW-hazard queries.
// Optional `WB_BYPASS_EN adds query_data_1/2 carrying the youngest matching queued result.
module writeback_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int DEPTH         = 4,
  localparam int REG_W        = $clog2(NUM_REGISTERS),
  localparam int OCC_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  // valid/ready: a source holds valid with stable rd/data; the result is taken on the
  // posedge where valid & ready. Ready depends only on current occupancy and alu_valid.
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_W-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_W-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [REG_W-1:0]      write_register,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [REG_W-1:0]      query_register_1,
  input  logic [REG_W-1:0]      query_register_2,
  output logic                  query_pending_1,
  output logic                  query_pending_2,
`ifdef WB_BYPASS_EN
  output logic [DATA_WIDTH-1:0] query_data_1,
  output logic [DATA_WIDTH-1:0] query_data_2,
`endif
  output logic [OCC_W-1:0]      occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [REG_W-1:0]      rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      mem_slot;
  logic [OCC_W-1:0]      free;
  logic                  alu_store;
  logic                  mem_store;
  logic                  pop;

  assign free      = OCC_W'(DEPTH) - occupancy;
  assign alu_ready = (free != '0);
  assign mem_ready = alu_valid ? (free >= OCC_W'(2)) : (free != '0);

  // Writes to r0 are handshaken away without taking a slot.
  assign alu_store = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_store = mem_valid && mem_ready && (mem_rd != '0);
  assign mem_slot  = tail + PTR_W'(alu_store);
  assign pop       = (occupancy != '0);

  assign write_register = pop ? rd_q[head]   : '0;
  assign write_data     = pop ? data_q[head] : '0;

  logic [PTR_W-1:0]      idx;
  logic                  pend_1;
  logic                  pend_2;
  logic [DATA_WIDTH-1:0] byp_1;
  logic [DATA_WIDTH-1:0] byp_2;

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    idx    = '0;
    pend_1 = 1'b0;
    pend_2 = 1'b0;
    byp_1  = '0;
    byp_2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (OCC_W'(i) < occupancy) begin
        if ((query_register_1 != '0) && (rd_q[idx] == query_register_1)) begin
          pend_1 = 1'b1;
          byp_1  = data_q[idx];
        end
        if ((query_register_2 != '0) && (rd_q[idx] == query_register_2)) begin
          pend_2 = 1'b1;
          byp_2  = data_q[idx];
        end
      end
    end
  end

  assign query_pending_1 = pend_1;
  assign query_pending_2 = pend_2;
`ifdef WB_BYPASS_EN
  assign query_data_1 = byp_1;
  assign query_data_2 = byp_2;
`else
  logic unused_byp;
  assign unused_byp = ^{byp_1, byp_2};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (alu_store) begin
        rd_q[tail]   <= alu_rd;
        data_q[tail] <= alu_data;
      end
      if (mem_store) begin
        rd_q[mem_slot]   <= mem_rd;
        data_q[mem_slot] <= mem_data;
      end
      head      <= head + PTR_W'(pop);
      tail      <= tail + PTR_W'(alu_store) + PTR_W'(mem_store);
      occupancy <= occupancy + OCC_W'(alu_store) + OCC_W'(mem_store) - OCC_W'(pop);
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic against a queue model.
module tb_writeback_queue;
  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 4;
  localparam int EW    = RW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [RW-1:0] alu_rd, mem_rd, query_register_1, query_register_2, write_register;
  logic [DW-1:0] alu_data, mem_data, write_data;
  logic          query_pending_1, query_pending_2;
  logic [2:0]    occupancy;
`ifdef WB_BYPASS_EN
  logic [DW-1:0] query_data_1, query_data_2;
`endif

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  writeback_queue dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .write_register(write_register), .write_data(write_data),
    .query_register_1(query_register_1), .query_register_2(query_register_2),
    .query_pending_1(query_pending_1), .query_pending_2(query_pending_2),
`ifdef WB_BYPASS_EN
    .query_data_1(query_data_1), .query_data_2(query_data_2),
`endif
    .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model helpers
  function automatic logic model_pending(input logic [RW-1:0] q);
    logic hit = 1'b0;
    foreach (exp_q[i]) if (q != 0 && exp_q[i][EW-1:DW] == q) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [DW-1:0] model_youngest(input logic [RW-1:0] q);
    logic [DW-1:0] d = '0;
    foreach (exp_q[i]) if (q != 0 && exp_q[i][EW-1:DW] == q) d = exp_q[i][DW-1:0];
    return d;
  endfunction

  task automatic check_outputs(input string tag);
    int free = DEPTH - exp_q.size();
    check_eq({tag, "_alu_rdy"}, alu_ready, free >= 1);
    check_eq({tag, "_mem_rdy"}, mem_ready, alu_valid ? (free >= 2) : (free >= 1));
    check_eq({tag, "_occ"}, occupancy, exp_q.size());
    check_eq({tag, "_wreg"}, write_register, exp_q.size() != 0 ? exp_q[0][EW-1:DW] : 0);
    check_eq({tag, "_wdata"}, write_data, exp_q.size() != 0 ? exp_q[0][DW-1:0] : 0);
    check_eq({tag, "_pend1"}, query_pending_1, model_pending(query_register_1));
    check_eq({tag, "_pend2"}, query_pending_2, model_pending(query_register_2));
`ifdef WB_BYPASS_EN
    check_eq({tag, "_byp1"}, query_data_1, model_youngest(query_register_1));
    check_eq({tag, "_byp2"}, query_data_2, model_youngest(query_register_2));
`endif
  endtask

  // driver: called just after a posedge; drives, checks, clocks, updates model
  task automatic drive_cycle(input string tag,
                             input logic av, input logic [RW-1:0] ard, input logic [DW-1:0] ad,
                             input logic mv, input logic [RW-1:0] mrd, input logic [DW-1:0] md,
                             input logic [RW-1:0] q1, input logic [RW-1:0] q2);
    int  free;
    logic a_acc, m_acc;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    query_register_1 = q1; query_register_2 = q2;
    #2;
    check_outputs(tag);
    free  = DEPTH - exp_q.size();
    a_acc = av && free >= 1;
    m_acc = mv && (av ? free >= 2 : free >= 1);
    @(posedge clk);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (a_acc && ard != 0) exp_q.push_back({ard, ad});
    if (m_acc && mrd != 0) exp_q.push_back({mrd, md});
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    drive_cycle(tag, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    query_register_1 = '0; query_register_2 = '0;

    // reset held with alu_valid asserted
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wreg", write_register, 0);
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_alu_rdy", alu_ready, 1);
    check_eq("rst_mem_rdy", mem_ready, 1);
    @(negedge clk);
    alu_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single ALU result, then retire
    drive_cycle("t2_in", 1'b1, 5'd5, 32'hA5, 1'b0, '0, '0, 5'd5, '0);
    alu_valid = 1'b0; #1;
    check_eq("t2_wreg", write_register, 5);
    check_eq("t2_wdata", write_data, 32'hA5);
    idle_cycle("t2_drain");
    check_eq("t2_empty", write_register, 0);

    // ALU + mem same cycle -> ALU older
    drive_cycle("t3_in", 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
    check_eq("t3_first", write_register, 3);
    idle_cycle("t3_a");
    check_eq("t3_second", write_register, 4);
    check_eq("t3_second_d", write_data, 32'h22);
    idle_cycle("t3_b");

    // fill with both sources every cycle
    drive_cycle("t4_a", 1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, 5'd10, 5'd11);
    drive_cycle("t4_b", 1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103, 5'd12, 5'd13);
    alu_valid = 1'b1; mem_valid = 1'b1; #1;
    check_eq("t4_occ3", occupancy, 3);
    check_eq("t4_mem_rdy0", mem_ready, 0);
    check_eq("t4_alu_rdy1", alu_ready, 1);
    drive_cycle("t4_c", 1'b1, 5'd14, 32'h104, 1'b1, 5'd15, 32'h105, 5'd14, 5'd15);
    drive_cycle("t4_d", 1'b1, 5'd16, 32'h106, 1'b1, 5'd17, 32'h107, 5'd15, 5'd17);
    while (exp_q.size() != 0) idle_cycle("t4_drain");

    // rd=0 consumed but not stored; hazard query
    drive_cycle("t5_r0", 1'b1, 5'd0, 32'hFF, 1'b0, '0, '0, '0, '0);
    check_eq("t5_occ", occupancy, 0);
    check_eq("t5_wreg", write_register, 0);
    drive_cycle("t5_r7", 1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 5'd7, '0);
    alu_valid = 1'b0; query_register_1 = 5'd7; query_register_2 = 5'd0; #1;
    check_eq("t5_pend7", query_pending_1, 1);
    check_eq("t5_pend0", query_pending_2, 0);
    idle_cycle("t5_drain");

`ifdef WB_BYPASS_EN
    drive_cycle("byp_in", 1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, '0, '0);
    alu_valid = 1'b0; mem_valid = 1'b0; query_register_1 = 5'd9; #1;
    check_eq("byp_young", query_data_1, 32'h2);
    idle_cycle("byp_a");
    idle_cycle("byp_b");
`endif

    // reset mid-operation with three entries queued
    drive_cycle("t6_a", 1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h201, '0, '0);
    drive_cycle("t6_b", 1'b1, 5'd22, 32'h202, 1'b1, 5'd23, 32'h203, '0, '0);
    alu_valid = 1'b0; mem_valid = 1'b0; #1;
    check_eq("t6_occ3", occupancy, 3);
    rst = 1'b0;
    #1;
    exp_q.delete();
    check_eq("t6_wreg", write_register, 0);
    check_eq("t6_occ0", occupancy, 0);
    check_eq("t6_alu_rdy", alu_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_post_occ", occupancy, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive_cycle("rnd",
                  1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)), $urandom,
                  RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)));
    end
    while (exp_q.size() != 0) idle_cycle("rnd_drain");
    idle_cycle("final_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // bound the run in case anything stalls
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
